// File: rtl/uart_tx_parity_if.sv
// Host-side handshake between the write side (host/FIFO) and the
// parity UART transmitter: request, data word, and frame status.
interface uart_tx_parity_if;
  logic       tx_start;
  logic [7:0] din;
  logic       tx_done_tick;
  logic       tx_busy;
  logic       tx_parity;

  // Host issues requests and observes completion/status.
  modport master (
    output tx_start,
    output din,
    input  tx_done_tick,
    input  tx_busy,
    input  tx_parity
  );

  // Transmitter accepts requests and reports completion/status.
  modport slave (
    input  tx_start,
    input  din,
    output tx_done_tick,
    output tx_busy,
    output tx_parity
  );
endinterface

// File: rtl/uart_tx_parity.sv
// UART transmitter with even parity: start, DBIT data bits LSB first,
// parity, stop. Bit timing follows the shared 16x oversampling s_tick so
// frames line up bit-for-bit with the parity-checking receiver.
module uart_tx_parity #(
  parameter int DBIT    = 8,   // data bits per frame, 5..8
  parameter int SB_TICK = 16   // s_ticks in the stop phase (16/24/32)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_tick,
  uart_tx_parity_if.slave  host,
  output logic             tx
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Last oversample index of a start/data/parity bit, of the stop phase,
  // and of the data-bit counter.
  localparam logic [4:0] S_BIT_LAST  = 5'd15;
  localparam logic [4:0] S_STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST      = 3'(DBIT - 1);

  state_t     state_reg, state_next;
  logic [4:0] s_reg, s_next;
  logic [2:0] n_reg, n_next;
  logic [7:0] b_reg, b_next;
  logic       p_reg, p_next;
  logic       tx_reg, tx_next;
  logic       done;

  // State and datapath registers; reset parks the line high and idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= 5'd0;
      n_reg     <= 3'd0;
      b_reg     <= 8'd0;
      p_reg     <= 1'b0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      p_reg     <= p_next;
      tx_reg    <= tx_next;
    end
  end

  // Next-state, counter and shift/parity update; everything holds when
  // s_tick is absent.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    p_next     = p_reg;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        // A request needs no s_tick; the start bit begins on the next edge.
        if (host.tx_start) begin
          b_next     = host.din;
          p_next     = 1'b0;
          s_next     = 5'd0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == S_BIT_LAST) begin
            s_next     = 5'd0;
            n_next     = 3'd0;
            state_next = DATA;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == S_BIT_LAST) begin
            // Fold the bit just sent into the running parity, then expose
            // the next bit at position 0.
            p_next = p_reg ^ b_reg[0];
            b_next = {1'b0, b_reg[7:1]};
            s_next = 5'd0;
            if (n_reg == N_LAST) begin
              state_next = PARITY;
            end else begin
              n_next = n_reg + 3'd1;
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_reg == S_BIT_LAST) begin
            s_next     = 5'd0;
            state_next = STOP;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_reg == S_STOP_LAST) begin
            // A request in this same cycle is ignored because the state
            // is still STOP; the next edge returns to IDLE.
            done       = 1'b1;
            s_next     = 5'd0;
            state_next = IDLE;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      default: begin
        // Illegal encoding: recover to a clean idle line.
        state_next = IDLE;
        s_next     = 5'd0;
        n_next     = 3'd0;
        b_next     = 8'd0;
        p_next     = 1'b0;
      end
    endcase
  end

  // Line level derived from the upcoming state so the registered tx
  // changes exactly on the bit boundary without glitches.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      PARITY:  tx_next = p_next;
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

  assign tx                = tx_reg;
  assign host.tx_done_tick = done;
  assign host.tx_busy      = (state_reg != IDLE);
  assign host.tx_parity    = p_reg;

endmodule

// File: tb/tb_uart_tx_parity.sv
// Bench for uart_tx_parity: two configurations (8 data/16 stop ticks and
// 7 data/32 stop ticks) checked cycle by cycle against a frame model that
// maps the count of s_ticks since acceptance onto the expected bit list.
module tb_uart_tx_parity;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       start_r;
  logic [7:0] din_r;
  int         sel;
  logic       tx8, tx7;

  int n_cmp = 0;
  int n_err = 0;
  logic last_par [2];

  uart_tx_parity_if if8 ();
  uart_tx_parity_if if7 ();

  assign if8.tx_start = start_r && (sel == 0);
  assign if7.tx_start = start_r && (sel == 1);
  assign if8.din      = din_r;
  assign if7.din      = din_r;

  uart_tx_parity #(.DBIT(8), .SB_TICK(16)) dut8 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .host(if8), .tx(tx8)
  );
  uart_tx_parity #(.DBIT(7), .SB_TICK(32)) dut7 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .host(if7), .tx(tx7)
  );

  logic tx_obs, busy_obs, done_obs, par_obs;
  always_comb begin
    tx_obs   = (sel == 0) ? tx8 : tx7;
    busy_obs = (sel == 0) ? if8.tx_busy : if7.tx_busy;
    done_obs = (sel == 0) ? if8.tx_done_tick : if7.tx_done_tick;
    par_obs  = (sel == 0) ? if8.tx_parity : if7.tx_parity;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected level of frame bit idx: 0 start, 1..dbit data, dbit+1 parity, else stop.
  function automatic logic frame_bit(input logic [7:0] d, input int dbit, input int idx);
    logic [7:0] dd;
    dd = d;
    if (idx == 0) return 1'b0;
    if (idx <= dbit) return dd[idx-1];
    if (idx == dbit + 1) return ^(dd & 8'((1 << dbit) - 1));
    return 1'b1;
  endfunction

  function automatic logic tick_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 4) == 3;
    return $urandom_range(0, 2) == 0;
  endfunction

  // Sends one frame on instance `which` and checks every cycle until the
  // frame completes. inj_mid_k >= 0 raises a stray request at that tick
  // count; inj_done raises one alongside the done pulse; abort_k >= 0
  // asserts reset when that tick count is reached.
  task automatic run_frame(input int which, input logic [7:0] d, input int mode,
                           input int inj_mid_k, input bit inj_done, input int abort_k);
    int dbit, sbt, total, k, cyc, idx;
    logic exp_par, exp_done, pbit;
    logic [11:0] rx_bits;
    logic [7:0]  rx_word, mask;
    dbit    = (which == 0) ? 8 : 7;
    sbt     = (which == 0) ? 16 : 32;
    total   = 16 * (dbit + 2) + sbt;
    mask    = 8'((1 << dbit) - 1);
    exp_par = ^(d & mask);
    rx_bits = '1;
    @(negedge clk);
    sel = which;
    #1;
    chk("idle_tx", tx_obs, 1);
    chk("idle_busy", busy_obs, 0);
    chk("idle_par", par_obs, last_par[which]);
    start_r = 1'b1;
    din_r   = d;
    s_tick  = tick_for(mode, 0);
    @(posedge clk);
    k   = 0;
    cyc = 0;
    while (k < total && cyc < 4000) begin
      @(negedge clk);
      start_r = 1'b0;
      din_r   = 8'($urandom);
      if (abort_k >= 0 && k == abort_k) begin
        reset = 1'b1;
        #1;
        chk("abort_tx", tx_obs, 1);
        chk("abort_busy", busy_obs, 0);
        chk("abort_done", done_obs, 0);
        chk("abort_par", par_obs, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        last_par[0] = 1'b0;
        last_par[1] = 1'b0;
        return;
      end
      idx = k / 16;
      chk("tx", tx_obs, frame_bit(d, dbit, idx));
      chk("busy", busy_obs, 1);
      if (k >= 16 * (dbit + 1)) chk("parity_out", par_obs, exp_par);
      if ((k % 16) == 8 && idx < 12) rx_bits[idx] = tx_obs;
      if (inj_mid_k >= 0 && k == inj_mid_k) begin
        start_r = 1'b1;
        din_r   = 8'hFF;
      end
      s_tick   = tick_for(mode, cyc + 1);
      exp_done = (k == total - 1) && s_tick;
      if (inj_done && exp_done) start_r = 1'b1;
      #1;
      chk("done", done_obs, exp_done);
      @(posedge clk);
      if (s_tick) k++;
      cyc++;
    end
    chk("frame_complete", k, total);
    if (mode == 0) chk("busy_cycles", cyc, total);
    rx_word = '0;
    for (int i = 0; i < dbit; i++) rx_word[i] = rx_bits[i+1];
    pbit = rx_bits[dbit+1];
    chk("rx_start", rx_bits[0], 0);
    chk("rx_word", rx_word, d & mask);
    chk("rx_parity_err", (^rx_word) ^ pbit, 0);
    chk("rx_stop", rx_bits[dbit+2], 1);
    last_par[which] = exp_par;
  endtask

  initial begin
    logic [7:0] rd;
    reset       = 1'b1;
    start_r     = 1'b0;
    din_r       = 8'h00;
    s_tick      = 1'b0;
    sel         = 0;
    last_par[0] = 1'b0;
    last_par[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx8", tx8, 1);
    chk("rst_busy8", if8.tx_busy, 0);
    chk("rst_done8", if8.tx_done_tick, 0);
    chk("rst_par8", if8.tx_parity, 0);
    chk("rst_tx7", tx7, 1);
    chk("rst_busy7", if7.tx_busy, 0);
    reset = 1'b0;

    // Basic frame with s_tick tied high.
    run_frame(0, 8'hA5, 0, -1, 1'b0, -1);
    // Odd and zero parity words.
    run_frame(0, 8'h07, 0, -1, 1'b0, -1);
    run_frame(0, 8'h00, 0, -1, 1'b0, -1);
    // Back-to-back words with s_tick every 4 clk.
    run_frame(0, 8'h00, 1, -1, 1'b0, -1);
    run_frame(0, 8'hFF, 1, -1, 1'b0, -1);
    run_frame(0, 8'h55, 1, -1, 1'b0, -1);
    run_frame(0, 8'h80, 1, -1, 1'b0, -1);
    run_frame(0, 8'h3C, 1, -1, 1'b0, -1);
    // Requests while busy and alongside the done pulse are ignored.
    run_frame(0, 8'h12, 2, 16 * 3 + 5, 1'b1, -1);
    run_frame(0, 8'hC3, 0, -1, 1'b0, -1);
    // Seven data bits with a double-length stop.
    run_frame(1, 8'h81, 0, -1, 1'b0, -1);
    run_frame(1, 8'h6E, 2, -1, 1'b0, -1);
    // Reset at the third data bit, then a clean frame.
    run_frame(0, 8'h96, 2, -1, 1'b0, 48);
    run_frame(0, 8'h5A, 0, -1, 1'b0, -1);
    // Random words, random tick spacing, both configurations.
    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom);
      run_frame(i % 2, rd, 2, -1, 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_parity.md
Name: uart_tx_parity

Overview:
UART transmitter that is the transmit-side counterpart of the team's parity-checking UART receiver. It serializes one data word per request as: start bit, DBIT data bits LSB first, one even-parity bit, then stop. Bit timing comes from the shared 16x oversampling baud tick (s_tick), so the frame format and timing match the receiver bit-for-bit. It sits between the host/FIFO write side and the serial TX pin.

Parameters:
DBIT, 8, number of data bits per frame (valid 5..8); only din[DBIT-1:0] is sent.
SB_TICK, 16, number of s_tick periods in the stop phase (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
tx_start  input  1  single-cycle request to send din; honoured only in IDLE.
s_tick  input  1  16x-baud enable pulse, one clk wide.
din  input  8  data word, sampled on the accepted tx_start cycle.
tx_done_tick  output  1  one-clk pulse at the end of the stop phase.
tx_busy  output  1  high whenever state != IDLE.
tx_parity  output  1  parity bit of the frame in flight (XOR of sent data bits).
tx  output  1  serial line, registered, idle high.

Behaviour:
- Clocking and reset: all state is on posedge clk with asynchronous reset. The reset values are: state = IDLE, tx register = 1, s counter = 0, n counter = 0, shift register = 0, parity register = 0. During and after reset, tx = 1, tx_busy = 0, tx_done_tick = 0 and tx_parity = 0.
- Reset mid-frame aborts the frame immediately: tx goes to 1 asynchronously, and no tx_done_tick is produced.
- State machine uses a 3-bit state register with states IDLE, START, DATA, PARITY, STOP. Any illegal encoding goes to IDLE and clears all counters and registers.
- IDLE:
  - tx = 1.
  - On tx_start: load the shift register with din, clear the parity register, set s = 0, go to START.
  - tx drives 0 from the next clk edge. s_tick is not required to accept a request.
- START:
  - tx = 0.
  - s increments on each s_tick.
  - On s_tick with s == 15: s = 0, n = 0, go to DATA.
- DATA:
  - tx = shift register bit 0.
  - On s_tick with s == 15:
    - parity register ^= shift register bit 0;
    - shift right by one (zero fill), s = 0;
    - if n == DBIT-1 go to PARITY, else n = n+1.
  - Otherwise, on s_tick, s = s+1.
- PARITY:
  - tx = parity register, which is even parity: the data ones plus the parity bit total an even count.
  - On s_tick with s == 15: s = 0, go to STOP.
- STOP:
  - tx = 1.
  - On s_tick with s == SB_TICK-1: tx_done_tick = 1 for that clk, go to IDLE.
  - Otherwise, on s_tick, s = s+1.
- tx register: next tx is computed combinationally from next state and registered, so tx is glitch-free.
- Timing: each start, data and parity bit lasts exactly 16 s_ticks; the stop phase lasts SB_TICK s_ticks. With SB_TICK = 16 a frame is 16*(DBIT+3) s_ticks.
- s counter is 5 bits wide so that SB_TICK up to 32 is supported. n counter is 3 bits wide.
- tx_start while busy is ignored; there is no queueing and din changes are ignored.
- tx_start in the same cycle as tx_done_tick is ignored, because the state is still STOP. The earliest new request is accepted on the cycle after tx_done_tick, which gives back-to-back frames with no idle bit.
- s_tick absent: all counters hold and tx holds.
- tx_parity = parity register. It is valid from PARITY entry until the next accepted tx_start.
- tx_busy is combinational from the state register.

Test Plan:
1. s_tick tied high, DBIT=8, SB_TICK=16, tx_start with din=8'hA5 -> tx low for 16 clk, then bits 1,0,1,0,0,1,0,1 at 16 clk each, parity 0, stop high 16 clk. tx_done_tick pulses once at clk 176 after the start edge; tx_busy is high for exactly 176 clk.
2. din=8'h07 -> data bits 1,1,1,0,0,0,0,0, parity bit 1 and tx_parity = 1. Then din=8'h00 -> parity 0 and tx low for 144 consecutive clk (start plus 8 data bits) before parity (0) and stop.
3. Loopback: tx into the receiver (same DBIT/SB_TICK) with s_tick every 4 clk, sending 0x00, 0xFF, 0x55, 0x80, 0x3C back-to-back (tx_start on the cycle after each tx_done_tick) -> receiver dout matches each word, its parity error output never asserts, and 5 rx_done_ticks occur.
4. During DATA of 0x12, assert tx_start with din=0xFF -> ignored; the frame carries 0x12 and exactly one tx_done_tick occurs. Also assert tx_start in the same cycle as tx_done_tick -> no new frame starts.
5. DBIT=7, SB_TICK=32, din=8'h81 -> 7 data bits 1,0,0,0,0,0,0 (bit 7 dropped), parity 1, stop high for 32 s_ticks. Frame length = 16*9+32 = 176 s_ticks.
6. Assert reset at the 3rd data bit -> tx = 1 and tx_busy = 0 immediately with no tx_done_tick. After release, a new tx_start with din=0x5A transmits a correct full frame.
